// File: rtl/alu_result_display.sv
// alu_result_display: latches one ALU result through a valid/ready handshake
// and renders it on five 7-segment digits (hex4 = MSD .. hex0 = LSD).
// Hex mode shows the low 20 bits as hex digits. Decimal mode converts the
// signed value with a sequential double-dabble, then shows sign and magnitude.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid        in_data/mode_dec are valid
//   in_ready        block can accept a value (only while idle)
//   in_data         two's complement value to show
//   mode_dec        1 = decimal render, 0 = hex render
//   done            one-cycle pulse when the display registers were updated
//   overflow        the value did not fit the last render
//   hex0..hex4      segments {g,f,e,d,c,b,a}, bit0 = a
module alu_result_display #(
   parameter int unsigned DATA_W         = 32,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              mode_dec,
   output logic              done,
   output logic              overflow,
   output logic [6:0]        hex0,
   output logic [6:0]        hex1,
   output logic [6:0]        hex2,
   output logic [6:0]        hex3,
   output logic [6:0]        hex4
);

   localparam int unsigned NDIG  = 10;
   localparam int unsigned BCD_W = 4 * NDIG;
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   localparam int unsigned SEG_W = 35;

   localparam logic [6:0] G_DASH  = 7'h40;
   localparam logic [6:0] G_BLANK = 7'h00;

   typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

   // Active-high glyph for one hex/BCD digit
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   // Apply output polarity
   function automatic logic [6:0] drive(input logic [6:0] g);
      return SEG_ACTIVE_LOW ? ~g : g;
   endfunction

   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   state_t              state;
   logic [DATA_W-1:0]   data_q;
   logic                mode_q;
   logic [DATA_W-1:0]   sh;
   logic [BCD_W-1:0]    bcd;
   logic [CNT_W-1:0]    cnt;
   logic [SEG_W-1:0]    stage_seg;
   logic                stage_ovf;
   logic                commit;

   logic                accept;
   logic [DATA_W-1:0]   mag;
   logic [BCD_W-1:0]    bcd_adj;
   logic [BCD_W-1:0]    bcd_nx;
   logic [DATA_W-1:0]   sh_nx;
   logic [SEG_W-1:0]    render_seg;
   logic                render_ovf;

   assign accept = (state == IDLE) && in_valid && in_ready;

   // Unsigned magnitude: the most negative value maps to 2^(DATA_W-1)
   assign mag = in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;

   // One double-dabble step: add 3 to digits >= 5, then shift left by one
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      {bcd_nx, sh_nx} = {bcd_adj, sh} << 1;
   end

   // Render the latched value (active-high glyphs) from data_q or the BCD result
   always_comb begin
      logic       neg;
      logic       lead;
      logic [3:0] d;
      render_seg = '0;
      render_ovf = 1'b0;
      neg        = data_q[DATA_W-1];
      lead       = 1'b1;
      d          = 4'h0;
      if (!mode_q) begin
         for (int i = 0; i < 5; i++) begin
            render_seg[7*i +: 7] = glyph(data_q[4*i +: 4]);
         end
         render_ovf = |data_q[DATA_W-1:20];
      end else begin
         // Leading zeros blank from the top down; digit 0 is always shown
         for (int i = 4; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            if (neg && (i == 4)) begin
               render_seg[7*i +: 7] = G_DASH;
            end else begin
               if ((d != 4'h0) || (i == 0)) begin
                  lead = 1'b0;
               end
               render_seg[7*i +: 7] = lead ? G_BLANK : glyph(d);
            end
         end
         render_ovf = neg ? (|bcd[BCD_W-1:16]) : (|bcd[BCD_W-1:20]);
         if (render_ovf) begin
            render_seg = {5{G_DASH}};
         end
      end
   end

   // FSM, conversion datapath and registered display outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         done      <= 1'b0;
         overflow  <= 1'b0;
         hex0      <= SEG_OFF;
         hex1      <= SEG_OFF;
         hex2      <= SEG_OFF;
         hex3      <= SEG_OFF;
         hex4      <= SEG_OFF;
         data_q    <= '0;
         mode_q    <= 1'b0;
         sh        <= '0;
         bcd       <= '0;
         cnt       <= '0;
         stage_seg <= '0;
         stage_ovf <= 1'b0;
         commit    <= 1'b0;
      end else begin
         done   <= 1'b0;
         commit <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q   <= in_data;
                  mode_q   <= mode_dec;
                  sh       <= mag;
                  bcd      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= mode_dec ? CONV : UPDATE;
               end
            end
            CONV: begin
               sh  <= sh_nx;
               bcd <= bcd_nx;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               // Render is staged here and committed to the pins next edge
               stage_seg <= render_seg;
               stage_ovf <= render_ovf;
               commit    <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // in_ready is still low here, so this never collides with an accept
         if (commit) begin
            hex0     <= drive(stage_seg[6:0]);
            hex1     <= drive(stage_seg[13:7]);
            hex2     <= drive(stage_seg[20:14]);
            hex3     <= drive(stage_seg[27:21]);
            hex4     <= drive(stage_seg[34:28]);
            overflow <= stage_ovf;
            done     <= 1'b1;
            in_ready <= 1'b1;
         end
      end
   end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Downstream consumer of the CPU's out_alu_result bus. Latches a 32-bit result through a valid/ready handshake and renders it on five 7-segment digits, hex4 (MSD) .. hex0 (LSD).
- Hex mode shows the low 20 bits as five hex digits.
- Decimal mode runs a sequential double-dabble conversion of the signed value, then shows it with sign and overflow handling.

Parameters:
- DATA_W, 32, input data width; also the double-dabble shift count.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a value
- in_data  input  DATA_W  ALU result, two's complement
- mode_dec  input  1  sampled with in_data; 1 = decimal, 0 = hex
- done  output  1  one-cycle pulse: display registers just updated
- overflow  output  1  value did not fit the last render
- hex0..hex4  output  7 each  segments {g,f,e,d,c,b,a}, bit0 = a

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (async, at any time, including mid-conversion):
  - state = IDLE, in_ready = 1, done = 0, overflow = 0.
  - All hex outputs blank (7'h7F when active-low).
  - Any in-flight conversion is discarded and produces no done.
- FSM states: IDLE, CONV, UPDATE.
- Accept: in IDLE with in_valid & in_ready at edge k.
  - Register in_data and mode_dec; in_ready goes low.
  - Next state: CONV if decimal, UPDATE if hex.
- in_valid while in_ready = 0 is ignored; no queuing.
- CONV:
  - Magnitude = |in_data|, computed as unsigned, so -2^31 gives 2^31.
  - Double-dabble: 10 BCD digits plus a DATA_W-bit shift register.
  - Each cycle: add 3 to every BCD digit that is >= 5, then shift left by 1.
  - A counter runs DATA_W cycles (edges k+1..k+DATA_W), then goes to UPDATE.
- UPDATE (one cycle): at the next edge, load the hex registers and overflow, pulse done = 1 for one cycle, set in_ready = 1, go to IDLE.
- Latency from accept edge to new display and done high:
  - Hex mode: 2 edges (edge k+2).
  - Decimal mode: DATA_W + 2 edges (edge k+34 at default).
- Back-to-back: a new accept is legal in the cycle where done is high.
- Hex render:
  - hexN = nibble N of in_data[19:0].
  - overflow = |in_data[DATA_W-1:20].
- Decimal render, value >= 0:
  - Digits 4..0 = BCD digits 4..0.
  - Leading zeros blanked; hex0 is always shown.
  - If magnitude > 99999: overflow = 1, all five digits show dash.
- Decimal render, value < 0:
  - hex4 = dash; digits 3..0 = BCD, with leading-zero blanking.
  - If magnitude > 9999: overflow = 1, all five digits show dash.
- Glyphs, active-high, before inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Dash = 40, blank = 00.
  - Output is inverted when SEG_ACTIVE_LOW = 1.
- Between updates, displays hold the last render.

Test Plan (SEG_ACTIVE_LOW = 1):
1. Reset:
   - Stimulus: hold rst = 1, then release.
   - Response: hex0..4 = 7'h7F, in_ready = 1, done = 0, overflow = 0.
2. Hex mode:
   - Stimulus: accept 32'h0001_2A3F.
   - Response at edge k+2: done = 1; hex4..hex0 = 79, 24, 08, 30, 0E; overflow = 0.
   - Stimulus: accept 32'h0010_0000.
   - Response: overflow = 1; all digits 40.
3. Decimal 12345 (32'h3039):
   - Response: in_ready = 0 for 34 cycles; done at edge k+34; hex4..hex0 = 79, 24, 30, 19, 12.
   - Extra stimulus: in_valid pulses during CONV.
   - Response: pulses are ignored and the displayed result is unchanged.
4. Decimal -42 (32'hFFFF_FFD6):
   - Response: hex4 = 3F, hex3 = 7F, hex2 = 7F, hex1 = 19, hex0 = 24, overflow = 0.
   - Stimulus: -2147483648.
   - Response: overflow = 1, all digits 3F.
5. Decimal overflow boundaries:
   - 99999: digits 10 ×5, overflow = 0.
   - 100000: all digits 3F, overflow = 1.
   - -9999: hex4 = 3F, rest 10, overflow = 0.
   - -10000: overflow = 1.
6. Reset mid-conversion:
   - Stimulus: assert rst in cycle 10 of CONV.
   - Response: immediate blank, no done, in_ready = 1.
   - Follow-up stimulus: accept decimal 0.
   - Response: hex0 = 40, hex1..hex4 = 7F.
